imm_gen_pipe: RTL and testbench

//  Registered, multi-lane immediate generator for the decode stage. Takes LANES packed 32-bit

---
 rtl/imm_gen_pipe.sv | 168 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Multi-lane RISC-V immediate generator for decode. Each accepted beat becomes a registered
// output beat, and a one-entry skid keeps full throughput while the consumer stalls.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*LANES-1:0]      in_inst,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN*LANES-1:0]    out_imm,
  output logic [3*LANES-1:0]       out_fmt,
  output logic [TAG_W-1:0]         out_tag,
  output logic [CNT_W-1:0]         unsup_cnt
);

  localparam int unsigned IMM_W = XLEN * LANES;
  localparam int unsigned FMT_W = 3 * LANES;
  localparam int unsigned SUM_W = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Base opcodes; the matrix ld/st group sits in the custom-0 slot
  localparam logic [6:0] op_itype_l = 7'b0000011;
  localparam logic [6:0] op_itype_a = 7'b0010011;
  localparam logic [6:0] op_itype_j = 7'b1100111;
  localparam logic [6:0] op_stype   = 7'b0100011;
  localparam logic [6:0] op_btype   = 7'b1100011;
  localparam logic [6:0] op_utype_l = 7'b0110111;
  localparam logic [6:0] op_utype_u = 7'b0010111;
  localparam logic [6:0] op_jtype   = 7'b1101111;
  localparam logic [6:0] op_mtype   = 7'b0001011;
  localparam logic [2:0] m_ld       = 3'b000;
  localparam logic [2:0] m_st       = 3'b001;

  localparam logic [2:0] fmt_none = 3'd0;
  localparam logic [2:0] fmt_i    = 3'd1;
  localparam logic [2:0] fmt_s    = 3'd2;
  localparam logic [2:0] fmt_b    = 3'd3;
  localparam logic [2:0] fmt_u    = 3'd4;
  localparam logic [2:0] fmt_j    = 3'd5;
  localparam logic [2:0] fmt_mld  = 3'd6;
  localparam logic [2:0] fmt_mst  = 3'd7;

  // Returns {fmt, imm sign-extended to 32 bits}; widening to XLEN happens per lane
  function automatic logic [34:0] decode_lane(input logic [31:0] inst);
    logic [2:0]  fmt;
    logic [31:0] imm;
    fmt = fmt_none;
    imm = '0;
    case (inst[6:0])
      op_itype_l, op_itype_a, op_itype_j: begin
        fmt = fmt_i;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      op_stype: begin
        fmt = fmt_s;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      op_btype: begin
        fmt = fmt_b;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      op_utype_l, op_utype_u: begin
        fmt = fmt_u;
        imm = {inst[31:12], 12'b0};
      end
      op_jtype: begin
        fmt = fmt_j;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      op_mtype: begin
        if (inst[14:12] == m_ld) begin
          fmt = fmt_mld;
          imm = {{20{inst[31]}}, inst[31:20]};
        end else if (inst[14:12] == m_st) begin
          fmt = fmt_mst;
          imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
      end
      default: ;
    endcase
    return {fmt, imm};
  endfunction

  logic [IMM_W-1:0] dec_imm;
  logic [FMT_W-1:0] dec_fmt;
  logic [LANES-1:0] lane_bad;
  logic [2:0]       n_bad;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [34:0] r;
    assign r                        = decode_lane(in_inst[32*k +: 32]);
    assign dec_imm[XLEN*k +: XLEN]  = XLEN'($signed(r[31:0]));
    assign dec_fmt[3*k +: 3]        = r[34:32];
    assign lane_bad[k]              = (r[34:32] == fmt_none);
  end

  always_comb begin
    n_bad = '0;
    for (int k = 0; k < LANES; k++) n_bad = n_bad + 3'(lane_bad[k]);
  end

  logic             accept;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  assign accept   = in_valid & in_ready;
  assign cnt_sum  = SUM_W'(unsup_cnt) + SUM_W'(n_bad);
  assign cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum);

  logic             skid_valid;
  logic [IMM_W-1:0] skid_imm;
  logic [FMT_W-1:0] skid_fmt;
  logic [TAG_W-1:0] skid_tag;

  // Output reg + skid reg; in_ready always mirrors an empty skid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_fmt    <= '0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= '0;
      skid_tag   <= '0;
      in_ready   <= 1'b1;
      unsup_cnt  <= '0;
    end else begin
      if (accept) unsup_cnt <= cnt_next;
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_imm    <= skid_imm;
          out_fmt    <= skid_fmt;
          out_tag    <= skid_tag;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end else begin
          out_valid <= accept;
          if (accept) begin
            out_imm <= dec_imm;
            out_fmt <= dec_fmt;
            out_tag <= in_tag;
          end
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_imm   <= dec_imm;
        skid_fmt   <= dec_fmt;
        skid_tag   <= in_tag;
        in_ready   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe (XLEN=64, LANES=2, CNT_W=4): known-answer table, handshake corner
// sequences, then random traffic against a two-deep FIFO reference model.
module tb_imm_gen_pipe;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned LANES = 2;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IMM_W = XLEN * LANES;
  localparam int unsigned FMT_W = 3 * LANES;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [32*LANES-1:0] in_inst;
  logic [TAG_W-1:0]    in_tag, out_tag;
  logic [IMM_W-1:0]    out_imm;
  logic [FMT_W-1:0]    out_fmt;
  logic [CNT_W-1:0]    unsup_cnt;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XLEN), .LANES(LANES), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag), .unsup_cnt(unsup_cnt)
  );

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic [FMT_W-1:0] fmt;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t       q[$];
  beat_t       held;
  int unsigned cnt;
  int          nvec = 0;
  int          nerr = 0;

  // Immediate from the format rules using signed arithmetic; returns {fmt, imm64}
  function automatic logic [66:0] ref_lane(input logic [31:0] i);
    int     s;
    longint v;
    logic [2:0] f;
    s = int'(i);
    v = 0;
    f = 3'd0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin f = 3'd1; v = longint'(s >>> 20); end
      7'h23: begin f = 3'd2; v = longint'(s >>> 25) * 32 + longint'(i[11:7]); end
      7'h63: begin
        f = 3'd3;
        v = (i[31] ? -longint'(4096) : longint'(0)) + longint'(i[7]) * 2048
            + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      7'h37, 7'h17: begin f = 3'd4; v = longint'(s & -4096); end
      7'h6F: begin
        f = 3'd5;
        v = (i[31] ? -longint'(1048576) : longint'(0)) + longint'(i[19:12]) * 4096
            + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      7'h0B: begin
        if (i[14:12] == 3'd0) begin f = 3'd6; v = longint'(s >>> 20); end
        else if (i[14:12] == 3'd1) begin f = 3'd7; v = longint'(s >>> 25) * 32 + longint'(i[11:7]); end
      end
      default: ;
    endcase
    return {f, 64'(v)};
  endfunction

  function automatic beat_t ref_beat(input logic [32*LANES-1:0] inst, input logic [TAG_W-1:0] tag);
    beat_t b;
    logic [66:0] r;
    b.tag = tag;
    b.imm = '0;
    b.fmt = '0;
    for (int k = 0; k < LANES; k++) begin
      r = ref_lane(inst[32*k +: 32]);
      b.imm[XLEN*k +: XLEN] = XLEN'(r[63:0]);
      b.fmt[3*k +: 3] = r[66:64];
    end
    return b;
  endfunction

  function automatic int unsigned ref_nbad(input logic [32*LANES-1:0] inst);
    logic [66:0] r;
    int unsigned n = 0;
    for (int k = 0; k < LANES; k++) begin
      r = ref_lane(inst[32*k +: 32]);
      if (r[66:64] == 3'd0) n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_model();
    chk("m_out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("m_in_ready",  128'(in_ready),  128'(q.size() < 2));
    chk("m_out_imm",   128'(out_imm),   128'(held.imm));
    chk("m_out_fmt",   128'(out_fmt),   128'(held.fmt));
    chk("m_out_tag",   128'(out_tag),   128'(held.tag));
    chk("m_unsup_cnt", 128'(unsup_cnt), 128'(cnt));
  endtask

  // Check current state, advance the model with the driven inputs, then clock
  task automatic step();
    bit acc, drn;
    check_model();
    acc = in_valid && (q.size() < 2);
    drn = out_ready && (q.size() > 0);
    if (rst) begin
      q.delete();
      cnt = 0;
      held = '0;
    end else begin
      if (acc) begin
        cnt = cnt + ref_nbad(in_inst);
        if (cnt > CMAX) cnt = CMAX;
      end
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(ref_beat(in_inst, in_tag));
      end
      if (q.size() > 0) held = q[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [32*LANES-1:0] inst, input int tag, input bit ordy);
    in_valid  = v;
    in_inst   = inst;
    in_tag    = TAG_W'(tag);
    out_ready = ordy;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0] ops [10];
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B, 7'h0B};
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    if (r[6:0] == 7'h0B && $urandom_range(0, 3) != 0) r[14:12] = 3'($urandom_range(0, 1));
    return r;
  endfunction

  typedef struct {
    logic [63:0]      inst;
    logic [IMM_W-1:0] imm;
    logic [FMT_W-1:0] fmt;
    int unsigned      cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{64'hFE000EE3_FFF00093, {64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF}, {3'd3, 3'd1}, 0};
    tbl[1] = '{64'h800000B7_FFFFF06F, {64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFE}, {3'd4, 3'd5}, 0};
    tbl[2] = '{64'hFE112E23_123450B7, {64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000}, {3'd2, 3'd4}, 0};
    tbl[3] = '{64'h00000000_00000013, {64'h0, 64'h0},                               {3'd0, 3'd1}, 1};
    tbl[4] = '{64'h8000108B_7FF0000B, {64'hFFFFFFFFFFFFF801, 64'h00000000000007FF}, {3'd7, 3'd6}, 1};
    tbl[5] = '{64'h00001017_0000200B, {64'h0000000000001000, 64'h0},               {3'd4, 3'd0}, 2};
    tbl[6] = '{64'hFFFFFFFF_FFC08067, {64'h0, 64'hFFFFFFFFFFFFFFFC},               {3'd0, 3'd1}, 3};

    rst = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    q.delete(); cnt = 0; held = '0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_imm",   128'(out_imm),   128'(0));
    chk("rst_cnt",       128'(unsup_cnt), 128'(0));
    rst = 1'b0;

    // Known-answer table, one beat per cycle with the consumer always ready
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, tbl[k].inst, k, 1'b1);
      step();
      chk("tbl_valid", 128'(out_valid), 128'(1));
      chk("tbl_imm",   128'(out_imm),   128'(tbl[k].imm));
      chk("tbl_fmt",   128'(out_fmt),   128'(tbl[k].fmt));
      chk("tbl_tag",   128'(out_tag),   128'(k));
      chk("tbl_cnt",   128'(unsup_cnt), 128'(tbl[k].cnt));
    end
    drive(1'b0, '0, 0, 1'b1);
    step();
    chk("idle_valid", 128'(out_valid), 128'(0));
    chk("idle_hold_imm", 128'(out_imm), 128'(tbl[6].imm));

    // Counter saturation: 14 more bad lanes on top of 3
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, '0, k, 1'b1);
      step();
    end
    chk("sat_cnt", 128'(unsup_cnt), 128'(CMAX));

    // Stall: three beats offered, two taken, drain in order
    drive(1'b0, '0, 0, 1'b1);
    step();
    drive(1'b1, 64'h00000013_FFF00093, 0, 1'b0); step();
    drive(1'b1, 64'h00000013_FFF00093, 1, 1'b0); step();
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    drive(1'b1, 64'h00000013_FFF00093, 2, 1'b0); step();
    chk("stall_in_ready2", 128'(in_ready), 128'(0));
    chk("stall_tag0",      128'(out_tag),  128'(0));
    chk("stall_valid",     128'(out_valid), 128'(1));
    drive(1'b0, '0, 0, 1'b1); step();
    chk("drain_tag1",     128'(out_tag),   128'(1));
    chk("drain_in_ready", 128'(in_ready),  128'(1));
    step();
    chk("drain_empty", 128'(out_valid), 128'(0));

    // Flush with both entries full
    drive(1'b1, 64'h00000013_00000013, 3, 1'b0); step();
    drive(1'b1, 64'h00000013_00000013, 4, 1'b0); step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid",    128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready),  128'(1));

    // Flush that drops, but still counts, a beat accepted the same cycle
    drive(1'b0, '0, 0, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    drive(1'b1, 64'h00000000_00000013, 5, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_drop_valid", 128'(out_valid), 128'(0));
    chk("flush_drop_cnt",   128'(unsup_cnt), 128'(1));

    // Reset while stalled with two beats
    drive(1'b1, 64'h00000000_FFFFF06F, 6, 1'b0); step();
    drive(1'b1, 64'h00000000_FFFFF06F, 7, 1'b0); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_valid",    128'(out_valid), 128'(0));
    chk("mrst_in_ready", 128'(in_ready),  128'(1));
    chk("mrst_imm",      128'(out_imm),   128'(0));
    chk("mrst_fmt",      128'(out_fmt),   128'(0));
    chk("mrst_tag",      128'(out_tag),   128'(0));
    chk("mrst_cnt",      128'(unsup_cnt), 128'(0));

    // Random traffic against the FIFO model
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(0, 3) != 0), {rand_inst(), rand_inst()}, int'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 0, 1'b1);
    step();
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
